// File: rtl/id_ex_pipeline_buffer.sv
// ID/EX pipeline register for the 16-bit datapath.
// It captures the decoded operands, the register-field lanes and the EX control word
// on every rising edge of C. The captured values are presented to EX for one full cycle.
// There is no combinational path from any input to any output.
// Hazard bubbles come from upstream muxing zeros into IC, so the buffer has no stall or flush input.
module id_ex_pipeline_buffer #(
    parameter int DATA_W = 16,
    parameter int CTRL_W = 4
) (
    output logic [DATA_W-1:0] OD1,
    output logic [DATA_W-1:0] OD2,
    output logic [DATA_W-1:0] OD15,
    output logic [DATA_W-1:0] ORS,
    output logic [DATA_W-1:0] ORT1,
    output logic [DATA_W-1:0] ORT2,
    output logic [DATA_W-1:0] ORD,
    output logic [CTRL_W-1:0] OC,
    input  logic [DATA_W-1:0] ID1,
    input  logic [DATA_W-1:0] ID2,
    input  logic [DATA_W-1:0] ID15,
    input  logic [DATA_W-1:0] IRS,
    input  logic [DATA_W-1:0] IRT1,
    input  logic [DATA_W-1:0] IRT2,
    input  logic [DATA_W-1:0] IRD,
    input  logic [CTRL_W-1:0] IC,
    input  logic              C,
    input  logic              R
);

    // Operand lanes: clear on synchronous reset, otherwise bit-exact capture
    always_ff @(posedge C) begin
        if (R) begin
            OD1  <= '0;
            OD2  <= '0;
            OD15 <= '0;
        end else begin
            OD1  <= ID1;
            OD2  <= ID2;
            OD15 <= ID15;
        end
    end

    // Register-field lanes: clear on synchronous reset, otherwise bit-exact capture
    always_ff @(posedge C) begin
        if (R) begin
            ORS  <= '0;
            ORT1 <= '0;
            ORT2 <= '0;
            ORD  <= '0;
        end else begin
            ORS  <= IRS;
            ORT1 <= IRT1;
            ORT2 <= IRT2;
            ORD  <= IRD;
        end
    end

    // EX control word: a cleared word acts as a bubble downstream
    always_ff @(posedge C) begin
        if (R) begin
            OC <= '0;
        end else begin
            OC <= IC;
        end
    end

endmodule

// File: tb/tb_id_ex_pipeline_buffer.sv
// Self-checking bench for id_ex_pipeline_buffer.
// It applies a table of vectors, followed by hand-written mid-cycle and back-to-back sequences.
module tb_id_ex_pipeline_buffer;

    logic        C = 1'b0;
    logic        R;
    logic [15:0] ID1, ID2, ID15, IRS, IRT1, IRT2, IRD;
    logic [3:0]  IC;
    logic [15:0] OD1, OD2, OD15, ORS, ORT1, ORT2, ORD;
    logic [3:0]  OC;

    always #5 C = ~C;

    id_ex_pipeline_buffer #(
        .DATA_W(16),
        .CTRL_W(4)
    ) dut (
        .OD1(OD1), .OD2(OD2), .OD15(OD15), .ORS(ORS),
        .ORT1(ORT1), .ORT2(ORT2), .ORD(ORD), .OC(OC),
        .ID1(ID1), .ID2(ID2), .ID15(ID15), .IRS(IRS),
        .IRT1(IRT1), .IRT2(IRT2), .IRD(IRD), .IC(IC),
        .C(C), .R(R)
    );

    typedef struct packed {
        logic [15:0] d1, d2, d15, rs, rt1, rt2, rd;
        logic [3:0]  c;
    } lanes_t;

    typedef struct {
        string  name;
        logic   r;
        lanes_t in;
        lanes_t exp;
    } vec_t;

    lanes_t sbq[$];
    int     checks = 0;
    int     errors = 0;

    function automatic lanes_t outs();
        lanes_t o;
        o = {OD1, OD2, OD15, ORS, ORT1, ORT2, ORD, OC};
        return o;
    endfunction

    task automatic drive(input logic r, input lanes_t v);
        R    = r;
        ID1  = v.d1;  ID2  = v.d2;  ID15 = v.d15; IRS = v.rs;
        IRT1 = v.rt1; IRT2 = v.rt2; IRD  = v.rd;  IC  = v.c;
    endtask

    task automatic check(input string nm, input string lane,
                         input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s.%s actual=%h expected=%h", nm, lane, act, exp);
        end
    endtask

    task automatic cmp(input string nm, input lanes_t a, input lanes_t e);
        check(nm, "OD1",  a.d1,  e.d1);
        check(nm, "OD2",  a.d2,  e.d2);
        check(nm, "OD15", a.d15, e.d15);
        check(nm, "ORS",  a.rs,  e.rs);
        check(nm, "ORT1", a.rt1, e.rt1);
        check(nm, "ORT2", a.rt2, e.rt2);
        check(nm, "ORD",  a.rd,  e.rd);
        check(nm, "OC",   {12'h000, a.c}, {12'h000, e.c});
    endtask

    // Drive one vector, queue its expectation, cross one edge, then pop and compare 1 time unit later.
    task automatic cycle(input string nm, input logic r, input lanes_t v, input lanes_t e);
        lanes_t x;
        drive(r, v);
        sbq.push_back(e);
        @(posedge C);
        #1;
        if (sbq.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s scoreboard empty actual=0 expected=1", nm);
        end else begin
            x = sbq.pop_front();
            cmp(nm, outs(), x);
        end
    endtask

    initial begin
        vec_t   tbl[8];
        lanes_t basic, rstin, alt, b15, zero, prev, nv;

        zero  = '0;
        basic = {16'h0A01, 16'h00B3, 16'hFFF0, 16'hE00F, 16'h0056, 16'h030F, 16'h200F, 4'h8};
        rstin = {16'h0A01, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 4'h8};
        alt   = {16'h1234, 16'h5678, 16'h9ABC, 16'hDEF0, 16'h0F0F, 16'hF0F0, 16'hA5A5, 4'h5};
        b15   = basic;
        b15.d15 = 16'h000F;

        tbl[0] = '{"reset_edge1",  1'b1, rstin, zero};
        tbl[1] = '{"reset_edge2",  1'b1, rstin, zero};
        tbl[2] = '{"basic_cap",    1'b0, basic, basic};
        tbl[3] = '{"lane_d15",     1'b0, b15,   b15};
        tbl[4] = '{"restore",      1'b0, basic, basic};
        tbl[5] = '{"reset_mid",    1'b1, alt,   zero};
        tbl[6] = '{"resume",       1'b0, alt,   alt};
        tbl[7] = '{"all_ones",     1'b0, '1,    '1};

        for (int unsigned i = 0; i < 8; i++)
            cycle(tbl[i].name, tbl[i].r, tbl[i].in, tbl[i].exp);

        // Mid-cycle stability: change ID2 and IC and pulse R between edges.
        cycle("pre_stable", 1'b0, basic, basic);
        ID2 = 16'h7E57;
        IC  = 4'h3;
        #1 R = 1'b1;
        #1 R = 1'b0;
        #1;
        cmp("hold_between_edges", outs(), basic);
        nv = basic;
        nv.d2 = 16'h7E57;
        nv.c  = 4'h3;
        cycle("after_mid_change", 1'b0, nv, nv);

        // Back-to-back: ID1 counts up, and every edge must show exactly the value driven before it.
        prev = nv;
        for (int unsigned k = 1; k <= 8; k++) begin
            prev.d1 = 16'(k);
            cycle("b2b", 1'b0, prev, prev);
        end

        // Reset held for several edges while inputs keep changing.
        for (int unsigned k = 0; k < 3; k++) begin
            nv = alt;
            nv.d1 = 16'(16'h4000 + k);
            cycle("reset_hold", 1'b1, nv, zero);
        end
        cycle("post_reset", 1'b0, alt, alt);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/id_ex_pipeline_buffer.md
Name: id_ex_pipeline_buffer

Overview:
- Pipeline register between the Instruction Decode (ID) and Execute (EX) stages of the 16-bit datapath.
- Captures decoded operands, register-specifier/index fields and the 4-bit EX control word on each rising clock edge.
- Presents the captured values to the EX stage for one full cycle.
- Purely registered: no combinational path from any input to any output.

Parameters:
- DATA_W, 16, width of every data/register-field lane (D1, D2, D15, RS, RT1, RT2, RD).
- CTRL_W, 4, width of the control lane.

Ports:
- C  input  1  clock; all state updates on its rising edge.
- R  input  1  reset; synchronous, active-high.
- OD1  output  DATA_W  registered read data 1 (first operand).
- OD2  output  DATA_W  registered read data 2 (second operand).
- OD15  output  DATA_W  registered R15 data (special/accumulator register value).
- ORS  output  DATA_W  registered RS field/value.
- ORT1  output  DATA_W  registered RT1 field/value.
- ORT2  output  DATA_W  registered RT2 field/value.
- ORD  output  DATA_W  registered RD (destination) field/value.
- OC  output  CTRL_W  registered EX control word.
- ID1, ID2, ID15, IRS, IRT1, IRT2, IRD  input  DATA_W  ID-stage values for the corresponding outputs.
- IC  input  CTRL_W  ID-stage control word.
- Positional port order is fixed as: OD1, OD2, OD15, ORS, ORT1, ORT2, ORD, OC, ID1, ID2, ID15, IRS, IRT1, IRT2, IRD, IC, C, R. Instantiations connect by position.

Behaviour:
- One clock domain (C). Reset is synchronous and active-high on R.
- Each output is its own register.
- At every rising edge of C with R=1: all eight outputs load 0 (OD*/OR* = 16'h0000, OC = 4'h0). Input values are ignored.
- At every rising edge of C with R=0: each output loads its paired input: OD1<=ID1, OD2<=ID2, OD15<=ID15, ORS<=IRS, ORT1<=IRT1, ORT2<=IRT2, ORD<=IRD, OC<=IC.
- Latency: exactly 1 cycle. A value present at the edge appears on the output just after that edge. It holds until the next edge.
- Between edges, outputs never change, whatever the inputs do.
- No enable, stall or flush input. The buffer captures every cycle; hazard handling is done upstream by muxing zeros into IC.
- Lanes are independent. Changing one input affects only its paired output.
- No width conversion, sign extension or arithmetic: bit-exact copy.
- Reset asserted mid-operation: the outputs clear at the first rising edge where R=1. They stay cleared while R=1. Normal capture resumes on the first edge with R=0.
- R toggling between edges has no effect; only R's value at the edge matters.
- Before the first edge, outputs are undefined (X in simulation). Benches apply reset for at least one edge.
- Undriven/X inputs captured with R=0 propagate as X. No masking.

Test Plan:
- Reset: drive all inputs to nonzero (ID1=16'h0A01, IC=4'h8, others 16'hFFFF), R=1 for 2 edges -> all outputs 0 after the first edge and held through the second.
- Basic capture: R=0; ID1=16'h0A01, ID2=16'h00B3, ID15=16'hFFF0, IRS=16'hE00F, IRT1=16'h0056, IRT2=16'h030F, IRD=16'h200F, IC=4'h8 -> each appears on its paired output one edge later, exactly.
- Lane independence and update: after capture, change only ID15 to 16'h000F -> OD15=16'h000F after the next edge; all other outputs keep their previous values.
- Mid-cycle stability: change ID2 and IC between edges -> OD2/OC unchanged until the next rising edge, then equal to the new values.
- Reset mid-stream: with outputs holding the basic-capture values, assert R=1 for one edge while the inputs change -> all outputs 0. Deassert R -> the next edge captures the current inputs.
- Back-to-back: a new input set each cycle (ID1=16'h0001, 16'h0002, 16'h0003…) -> OD1 follows with exactly one-cycle lag and no dropped or duplicated values.
